// File: rtl/key_pkg.sv
// Shared definitions for the key conditioner: board-rate default timings
// and the auto-repeat state encoding.
package key_pkg;

  // Defaults for a 50 MHz board clock
  localparam int KEY_DEBOUNCE_CYC = 1_000_000;  // 20 ms
  localparam int KEY_REPEAT_DLY   = 25_000_000; // 500 ms
  localparam int KEY_REPEAT_PER   = 10_000_000; // 200 ms

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RPT   = 2'd2
  } key_rpt_state_t;

endpackage

// File: rtl/key_conditioner_if.sv
// Key bus between the raw button inputs and the conditioned outputs.
// master: the side driving raw keys and consuming pulses.
// slave : the conditioner itself.
interface key_conditioner_if #(
  parameter int N_KEYS = 4
);

  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;

  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/key_channel.sv
// Single key channel: 2-FF synchroniser, debounce counter, stable level,
// registered press/release pulses. Optional auto-repeat is built only when
// KEY_CONDITIONER_REPEAT_EN is defined.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC,
  parameter int REPEAT_DLY   = KEY_REPEAT_DLY,
  parameter int REPEAT_PER   = KEY_REPEAT_PER
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int            DW      = $clog2(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] db_cnt;
  logic          accept;
  logic          acc_press;
  logic          acc_rel;
  logic          press_nxt;

  // The synchronised input has disagreed with the level long enough
  assign accept    = (s2 != key_level) && (db_cnt == DB_LAST);
  assign acc_press = accept & ~key_level;
  assign acc_rel   = accept &  key_level;

  // Two-flop synchroniser for the asynchronous raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  // Debounce: count while input differs from level, any agreement restarts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt    <= '0;
      key_level <= 1'b0;
    end else if (s2 != key_level) begin
      if (accept) begin
        key_level <= ~key_level;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam int            RMAX     = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int            RW       = $clog2(RMAX);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

  key_rpt_state_t state;
  key_rpt_state_t state_nxt;
  logic [RW-1:0]  rcnt;
  logic [RW-1:0]  rcnt_nxt;
  logic           rpt_fire;

  // Repeat state and interval counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  // Repeat sequencing; a release always wins and returns to IDLE.
  // The repeat counter only watches accepted edges, so debounce glitches
  // never disturb it.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rpt_fire  = 1'b0;
    case (state)
      IDLE: begin
        rcnt_nxt = '0;
        if (acc_press) state_nxt = FIRST;
      end
      FIRST: begin
        if (acc_rel) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else if (rcnt == DLY_LAST) begin
          rpt_fire  = 1'b1;
          rcnt_nxt  = '0;
          state_nxt = RPT;
        end else begin
          rcnt_nxt = rcnt + RW'(1);
        end
      end
      RPT: begin
        if (acc_rel) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else if (rcnt == PER_LAST) begin
          rpt_fire = 1'b1;
          rcnt_nxt = '0;
        end else begin
          rcnt_nxt = rcnt + RW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        rcnt_nxt  = '0;
      end
    endcase
  end

  assign press_nxt = acc_press | rpt_fire;
`else
  // Repeat timings have no effect in this build
  logic [31:0] unused_rpt_cfg;
  assign unused_rpt_cfg = REPEAT_DLY ^ REPEAT_PER;

  assign press_nxt = acc_press;
`endif

  // Registered one-cycle event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= press_nxt;
      key_release <= acc_rel;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel push-button conditioner: N_KEYS independent key_channel
// instances on one clock. Auto-repeat is enabled by defining
// KEY_CONDITIONER_REPEAT_EN.
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC,
  parameter int REPEAT_DLY   = KEY_REPEAT_DLY,
  parameter int REPEAT_PER   = KEY_REPEAT_PER
) (
  input  logic                clk,
  input  logic                rst,
  key_conditioner_if.slave    bus
);

  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] rel;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_PER   (REPEAT_PER)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_raw     (bus.key_raw[i]),
      .key_level   (level[i]),
      .key_press   (press[i]),
      .key_release (rel[i])
    );
  end

  assign bus.key_level   = level;
  assign bus.key_press   = press;
  assign bus.key_release = rel;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYC=8, REPEAT_DLY=20,
// REPEAT_PER=5. Expected values follow the edge-k + DEBOUNCE_CYC + 2 latency.
module tb_key_conditioner;

  localparam int N = 4;

`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_conditioner_if #(.N_KEYS(N)) bus_if ();

  key_conditioner #(
    .N_KEYS       (N),
    .DEBOUNCE_CYC (8),
    .REPEAT_DLY   (20),
    .REPEAT_PER   (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         press_cnt [N] = '{0, 0, 0, 0};
  int         rel_cnt   [N] = '{0, 0, 0, 0};
  int         overlap_cnt = 0;
  int         width_err   = 0;
  logic [N-1:0] prev_press = '0;
  logic [N-1:0] prev_rel   = '0;

  // Pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus_if.key_press[i])   press_cnt[i] <= press_cnt[i] + 1;
      if (bus_if.key_release[i]) rel_cnt[i]   <= rel_cnt[i] + 1;
    end
    if ((bus_if.key_press & bus_if.key_release) != '0)
      overlap_cnt <= overlap_cnt + 1;
    if (((bus_if.key_press & prev_press) | (bus_if.key_release & prev_rel)) != '0)
      width_err <= width_err + 1;
    prev_press <= bus_if.key_press;
    prev_rel   <= bus_if.key_release;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.key_raw = '0;

    // Reset state
    step(3);
    chk("reset_level",   32'(bus_if.key_level),   32'h0);
    chk("reset_press",   32'(bus_if.key_press),   32'h0);
    chk("reset_release", 32'(bus_if.key_release), 32'h0);
    rst = 1'b0;
    step(2);

    // 1: key0 press, edge k
    bus_if.key_raw[0] = 1'b1;
    step(9);
    chk("t1_level_k9", 32'(bus_if.key_level), 32'h0);
    chk("t1_press_k9", 32'(bus_if.key_press), 32'h0);
    step(1);
    chk("t1_level_k10", 32'(bus_if.key_level), 32'h1);
    chk("t1_press_k10", 32'(bus_if.key_press), 32'h1);
    // 5: repeat window, edges P0 .. P0+59
    step(1);
    chk("t1_press_width", 32'(bus_if.key_press[0]), 32'h0);
    step(19);
    chk("t5_press_p20", 32'(bus_if.key_press[0]), 32'(RPT_ON));
    step(5);
    chk("t5_press_p25", 32'(bus_if.key_press[0]), 32'(RPT_ON));
    step(34);
    chk("t5_press_count", 32'(press_cnt[0]), RPT_ON ? 32'd9 : 32'd1);

    // 3: release key0, edge m = P0+59
    bus_if.key_raw[0] = 1'b0;
    step(10);
    chk("t3_release_m10", 32'(bus_if.key_release[0]), 32'h1);
    chk("t3_level_m10",   32'(bus_if.key_level[0]),   32'h0);
    chk("t3_press_m10",   32'(bus_if.key_press[0]),   32'h0);
    step(1);
    chk("t3_release_width", 32'(bus_if.key_release[0]), 32'h0);

    // 2: key1 bounce, 3-cycle segments, final rise at edge f
    bus_if.key_raw[1] = 1'b1; step(3);
    bus_if.key_raw[1] = 1'b0; step(3);
    bus_if.key_raw[1] = 1'b1; step(3);
    bus_if.key_raw[1] = 1'b0; step(3);
    chk("t2_no_pulse_bounce", 32'(press_cnt[1]), 32'd0);
    bus_if.key_raw[1] = 1'b1;
    step(9);
    chk("t2_press_f9", 32'(bus_if.key_press[1]), 32'h0);
    step(1);
    chk("t2_press_f10", 32'(bus_if.key_press[1]), 32'h1);
    chk("t2_level_f10", 32'(bus_if.key_level),    32'h2);
    step(1);
    chk("t2_press_count", 32'(press_cnt[1]), 32'd1);

    // 4: key2 and key3 together
    bus_if.key_raw[3:2] = 2'b11;
    step(9);
    chk("t4_press_s9", 32'(bus_if.key_press[3:2]), 32'h0);
    step(1);
    chk("t4_press_s10", 32'(bus_if.key_press[3:2]), 32'h3);
    chk("t4_level_s10", 32'(bus_if.key_level),      32'he);

    // 6: key0 into RPT, key1 mid-debounce, then reset
    bus_if.key_raw[0] = 1'b1;
    step(10);
    chk("t6_press0", 32'(bus_if.key_press[0]), 32'h1);
    step(20);
    chk("t6_first_rpt", 32'(bus_if.key_press[0]), 32'(RPT_ON));
    step(3);
    bus_if.key_raw[1] = 1'b0;
    step(4);
    chk("t6_level_pre_rst", 32'(bus_if.key_level), 32'hf);
    rst = 1'b1;
    #1;
    chk("t6_rst_level",   32'(bus_if.key_level),   32'h0);
    chk("t6_rst_press",   32'(bus_if.key_press),   32'h0);
    chk("t6_rst_release", 32'(bus_if.key_release), 32'h0);
    step(2);
    rst = 1'b0;
    step(1);
    chk("t6_press_e1", 32'(bus_if.key_press), 32'h0);
    step(8);
    chk("t6_press_e9", 32'(bus_if.key_press), 32'h0);
    step(1);
    chk("t6_press_e10", 32'(bus_if.key_press), 32'hd);
    chk("t6_level_e10", 32'(bus_if.key_level), 32'hd);
    step(20);
    chk("t6_restart_first", 32'(bus_if.key_press), RPT_ON ? 32'hd : 32'h0);
    step(2);

    chk("no_press_release_overlap", 32'(overlap_cnt), 32'd0);
    chk("pulse_width_one",          32'(width_err),   32'd0);
    chk("release_count_key0",       32'(rel_cnt[0]),  32'd1);
    chk("release_count_key1",       32'(rel_cnt[1]),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
